// File: rtl/stg_mo_if.sv
// rtl/stg_mo_if.sv - dual-port data memory bus between the MO stage and the data RAM
interface stg_mo_if #(
   parameter int DATA_W = 24
);
   logic [DATA_W-1:0] iw_mem_rdata0;
   logic [DATA_W-1:0] iw_mem_rdata1;
   logic              ow_mem_we0;
   logic              ow_mem_we1;
   logic [DATA_W-1:0] ow_mem_wdata0;
   logic [DATA_W-1:0] ow_mem_wdata1;

   modport master (
      input  iw_mem_rdata0, iw_mem_rdata1,
      output ow_mem_we0, ow_mem_we1, ow_mem_wdata0, ow_mem_wdata1
   );

   modport slave (
      output iw_mem_rdata0, iw_mem_rdata1,
      input  ow_mem_we0, ow_mem_we1, ow_mem_wdata0, ow_mem_wdata1
   );
endinterface

// File: rtl/stg_mo.sv
// rtl/stg_mo.sv - pipeline stage 6: memory operation with two-beat 48-bit access sequencing
module stg_mo #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 48
) (
   input  logic              iw_clk,
   input  logic              iw_rst,
   input  logic [ADDR_W-1:0] iw_pc,
   input  logic [DATA_W-1:0] iw_instr,
   input  logic [7:0]        iw_opc,
   input  logic [3:0]        iw_tgt_gp,
   input  logic              iw_tgt_gp_we,
   input  logic [1:0]        iw_tgt_sr,
   input  logic              iw_tgt_sr_we,
   input  logic              iw_mem_mp,
   input  logic [ADDR_W-1:0] iw_addr,
   input  logic              iw_mem_rd,
   input  logic              iw_mem_wr,
   input  logic              iw_mem_wide,
   input  logic [DATA_W-1:0] iw_result,
   input  logic [ADDR_W-1:0] iw_sr_result,
   input  logic              iw_trap_pending,
   stg_mo_if.master          mem,
   output logic              ow_stall,
   output logic              ow_addr_ovr_en,
   output logic [ADDR_W-1:0] ow_addr_ovr,
   output logic [ADDR_W-1:0] ow_pc,
   output logic [DATA_W-1:0] ow_instr,
   output logic [7:0]        ow_opc,
   output logic [3:0]        ow_tgt_gp,
   output logic              ow_tgt_gp_we,
   output logic [1:0]        ow_tgt_sr,
   output logic              ow_tgt_sr_we,
   output logic [DATA_W-1:0] ow_result,
   output logic [ADDR_W-1:0] ow_sr_result
);

   typedef enum logic {IDLE, HI} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] rd_sel;
   logic              wr_any;
   logic [DATA_W-1:0] wr_dat;

   logic [ADDR_W-1:0] sh_pc;
   logic [DATA_W-1:0] sh_instr;
   logic [7:0]        sh_opc;
   logic [3:0]        sh_tgt_gp;
   logic              sh_tgt_gp_we;
   logic [1:0]        sh_tgt_sr;
   logic              sh_tgt_sr_we;
   logic              sh_wr;
   logic [DATA_W-1:0] r_lo;
   logic [DATA_W-1:0] r_hi;

   logic mem_req;
   assign mem_req     = (iw_mem_rd | iw_mem_wr) & ~iw_trap_pending;
   assign rd_sel      = iw_mem_mp ? mem.iw_mem_rdata1 : mem.iw_mem_rdata0;
   assign ow_addr_ovr = iw_addr + ADDR_W'(1);

   // Everything combinational is forced quiet while reset is held, including the HI beat.
   always_comb begin
      state_nxt          = state;
      ow_stall           = 1'b0;
      ow_addr_ovr_en     = 1'b0;
      wr_any             = 1'b0;
      wr_dat             = '0;
      mem.ow_mem_we0     = 1'b0;
      mem.ow_mem_we1     = 1'b0;
      mem.ow_mem_wdata0  = '0;
      mem.ow_mem_wdata1  = '0;
      if (!iw_rst) begin
         case (state)
            IDLE: begin
               if (mem_req && iw_mem_wide) begin
                  ow_stall       = 1'b1;
                  ow_addr_ovr_en = 1'b1;
                  state_nxt      = HI;
                  if (iw_mem_wr) begin
                     wr_any = 1'b1;
                     wr_dat = iw_sr_result[DATA_W-1:0];
                  end
               end else if (mem_req && iw_mem_wr) begin
                  wr_any = 1'b1;
                  wr_dat = iw_result;
               end
            end
            HI: begin
               state_nxt = IDLE;
               if (sh_wr) begin
                  wr_any = 1'b1;
                  wr_dat = r_hi;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
      if (wr_any) begin
         if (iw_mem_mp) begin
            mem.ow_mem_we1    = 1'b1;
            mem.ow_mem_wdata1 = wr_dat;
         end else begin
            mem.ow_mem_we0    = 1'b1;
            mem.ow_mem_wdata0 = wr_dat;
         end
      end
   end

   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         state        <= IDLE;
         ow_pc        <= '0;
         ow_instr     <= '0;
         ow_opc       <= '0;
         ow_tgt_gp    <= '0;
         ow_tgt_gp_we <= 1'b0;
         ow_tgt_sr    <= '0;
         ow_tgt_sr_we <= 1'b0;
         ow_result    <= '0;
         ow_sr_result <= '0;
         sh_pc        <= '0;
         sh_instr     <= '0;
         sh_opc       <= '0;
         sh_tgt_gp    <= '0;
         sh_tgt_gp_we <= 1'b0;
         sh_tgt_sr    <= '0;
         sh_tgt_sr_we <= 1'b0;
         sh_wr        <= 1'b0;
         r_lo         <= '0;
         r_hi         <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            ow_pc        <= iw_pc;
            ow_instr     <= iw_instr;
            ow_opc       <= iw_opc;
            ow_tgt_gp    <= iw_tgt_gp;
            ow_tgt_gp_we <= iw_tgt_gp_we & ~iw_trap_pending;
            ow_tgt_sr    <= iw_tgt_sr;
            ow_tgt_sr_we <= iw_tgt_sr_we & ~iw_trap_pending;
            ow_result    <= iw_result;
            ow_sr_result <= iw_sr_result;
            if (mem_req && iw_mem_wide) begin
               sh_pc        <= iw_pc;
               sh_instr     <= iw_instr;
               sh_opc       <= iw_opc;
               sh_tgt_gp    <= iw_tgt_gp;
               sh_tgt_gp_we <= iw_tgt_gp_we;
               sh_tgt_sr    <= iw_tgt_sr;
               sh_tgt_sr_we <= iw_tgt_sr_we;
               sh_wr        <= iw_mem_wr;
               r_lo         <= rd_sel;
               r_hi         <= iw_sr_result[ADDR_W-1:DATA_W];
               ow_tgt_gp_we <= 1'b0;
               ow_tgt_sr_we <= 1'b0;
            end else if (mem_req && iw_mem_rd && !iw_mem_wr) begin
               ow_result <= rd_sel;
            end
         end else begin
            // High beat: the instruction's own fields come back from the shadow copy.
            ow_pc        <= sh_pc;
            ow_instr     <= sh_instr;
            ow_opc       <= sh_opc;
            ow_tgt_gp    <= sh_tgt_gp;
            ow_tgt_gp_we <= sh_tgt_gp_we;
            ow_tgt_sr    <= sh_tgt_sr;
            ow_tgt_sr_we <= sh_tgt_sr_we;
            if (!sh_wr) ow_sr_result <= {rd_sel, r_lo};
         end
      end
   end

endmodule

// File: tb/tb_stg_mo.sv
// tb/tb_stg_mo.sv - directed self-checking bench for the memory-operation stage
module tb_stg_mo;
   localparam int DATA_W = 24;
   localparam int ADDR_W = 48;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] instr;
   logic [7:0]        opc;
   logic [3:0]        tgt_gp;
   logic              tgt_gp_we;
   logic [1:0]        tgt_sr;
   logic              tgt_sr_we;
   logic              mp;
   logic [ADDR_W-1:0] addr;
   logic              rd, wr, wide;
   logic [DATA_W-1:0] result;
   logic [ADDR_W-1:0] sr_result;
   logic              trap;
   logic              stall, ovr_en;
   logic [ADDR_W-1:0] ovr;
   logic [ADDR_W-1:0] o_pc;
   logic [DATA_W-1:0] o_instr;
   logic [7:0]        o_opc;
   logic [3:0]        o_tgt_gp;
   logic              o_tgt_gp_we;
   logic [1:0]        o_tgt_sr;
   logic              o_tgt_sr_we;
   logic [DATA_W-1:0] o_result;
   logic [ADDR_W-1:0] o_sr_result;

   int checks = 0;
   int errors = 0;

   stg_mo_if #(.DATA_W(DATA_W)) bus ();

   stg_mo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .iw_clk(clk), .iw_rst(rst),
      .iw_pc(pc), .iw_instr(instr), .iw_opc(opc),
      .iw_tgt_gp(tgt_gp), .iw_tgt_gp_we(tgt_gp_we),
      .iw_tgt_sr(tgt_sr), .iw_tgt_sr_we(tgt_sr_we),
      .iw_mem_mp(mp), .iw_addr(addr),
      .iw_mem_rd(rd), .iw_mem_wr(wr), .iw_mem_wide(wide),
      .iw_result(result), .iw_sr_result(sr_result),
      .iw_trap_pending(trap),
      .mem(bus.master),
      .ow_stall(stall), .ow_addr_ovr_en(ovr_en), .ow_addr_ovr(ovr),
      .ow_pc(o_pc), .ow_instr(o_instr), .ow_opc(o_opc),
      .ow_tgt_gp(o_tgt_gp), .ow_tgt_gp_we(o_tgt_gp_we),
      .ow_tgt_sr(o_tgt_sr), .ow_tgt_sr_we(o_tgt_sr_we),
      .ow_result(o_result), .ow_sr_result(o_sr_result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pc = '0; instr = '0; opc = '0; tgt_gp = '0; tgt_gp_we = 0; tgt_sr = '0; tgt_sr_we = 0;
      mp = 0; addr = '0; rd = 0; wr = 0; wide = 0; result = '0; sr_result = '0; trap = 0;
      bus.iw_mem_rdata0 = '0; bus.iw_mem_rdata1 = '0;
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      pc = 48'h55; wr = 1; result = 24'h123;
      #2;
      chk("rst_pc", o_pc, 0);
      chk("rst_result", o_result, 0);
      chk("rst_stall", stall, 0);
      chk("rst_we0", bus.ow_mem_we0, 0);
      step(); step();
      idle_inputs();
      rst = 0;

      // narrow store on port 0
      mp = 0; addr = 48'h10; wr = 1; result = 24'hABCDEF;
      #1;
      chk("st_we0", bus.ow_mem_we0, 1);
      chk("st_wdata0", bus.ow_mem_wdata0, 24'hABCDEF);
      chk("st_we1", bus.ow_mem_we1, 0);
      chk("st_wdata1", bus.ow_mem_wdata1, 0);
      step();

      // narrow load on port 1
      idle_inputs();
      mp = 1; addr = 48'h10; rd = 1; result = 24'h000999;
      bus.iw_mem_rdata1 = 24'hABCDEF; bus.iw_mem_rdata0 = 24'h000555;
      #1;
      chk("ld_we1", bus.ow_mem_we1, 0);
      step();
      chk("ld_result", o_result, 24'hABCDEF);

      // wide load at 0x20
      idle_inputs();
      mp = 0; addr = 48'h20; rd = 1; wide = 1; tgt_sr = 2; tgt_sr_we = 1; pc = 48'h200;
      bus.iw_mem_rdata0 = 24'h000111;
      #1;
      chk("wl_stall", stall, 1);
      chk("wl_ovr_en", ovr_en, 1);
      chk("wl_ovr", ovr, 48'h21);
      chk("wl_we0", bus.ow_mem_we0, 0);
      step();
      chk("wl_bubble_sr_we", o_tgt_sr_we, 0);
      idle_inputs();
      mp = 1; pc = 48'hDEAD; bus.iw_mem_rdata1 = 24'h000222;
      #1;
      chk("wl_hi_stall", stall, 0);
      chk("wl_hi_ovr_en", ovr_en, 0);
      step();
      chk("wl_sr_result", o_sr_result, 48'h000222000111);
      chk("wl_sr_we", o_tgt_sr_we, 1);
      chk("wl_tgt_sr", o_tgt_sr, 2);
      chk("wl_pc", o_pc, 48'h200);

      // wide store wrapping at the top of the address space
      idle_inputs();
      mp = 0; addr = 48'hFFFFFFFFFFFF; wr = 1; wide = 1; sr_result = 48'h123456789ABC;
      #1;
      chk("ws_we0", bus.ow_mem_we0, 1);
      chk("ws_wdata0", bus.ow_mem_wdata0, 24'h789ABC);
      chk("ws_we1", bus.ow_mem_we1, 0);
      chk("ws_ovr", ovr, 0);
      step();
      idle_inputs();
      mp = 1;
      #1;
      chk("ws_hi_we1", bus.ow_mem_we1, 1);
      chk("ws_hi_wdata1", bus.ow_mem_wdata1, 24'h123456);
      chk("ws_hi_we0", bus.ow_mem_we0, 0);
      chk("ws_hi_stall", stall, 0);
      step();

      // trap suppresses a wide store
      idle_inputs();
      mp = 0; addr = 48'h30; wr = 1; wide = 1; trap = 1; tgt_gp = 5; tgt_gp_we = 1;
      sr_result = 48'hAAAAAABBBBBB;
      #1;
      chk("tr_we0", bus.ow_mem_we0, 0);
      chk("tr_we1", bus.ow_mem_we1, 0);
      chk("tr_stall", stall, 0);
      step();
      chk("tr_gp_we", o_tgt_gp_we, 0);
      chk("tr_tgt_gp", o_tgt_gp, 5);
      idle_inputs();
      mp = 1;
      #1;
      chk("tr_after_we1", bus.ow_mem_we1, 0);

      // reset during the high beat of a wide store
      idle_inputs();
      mp = 0; addr = 48'h40; wr = 1; wide = 1; pc = 48'h77; sr_result = 48'h111111222222;
      step();
      idle_inputs();
      mp = 1;
      rst = 1;
      #1;
      chk("rh_we1", bus.ow_mem_we1, 0);
      chk("rh_stall", stall, 0);
      chk("rh_pc", o_pc, 0);
      chk("rh_sr_result", o_sr_result, 0);
      step();
      rst = 0;
      #1;
      chk("rh_post_we1", bus.ow_mem_we1, 0);
      chk("rh_post_stall", stall, 0);
      step();

      // ALU passthrough
      idle_inputs();
      pc = 48'h100; instr = 24'h00C0DE; opc = 8'h42; tgt_gp = 3; tgt_gp_we = 1;
      result = 24'h000777; sr_result = 48'h000000ABCDEF;
      #1;
      chk("pt_we0", bus.ow_mem_we0, 0);
      chk("pt_we1", bus.ow_mem_we1, 0);
      step();
      chk("pt_pc", o_pc, 48'h100);
      chk("pt_instr", o_instr, 24'h00C0DE);
      chk("pt_opc", o_opc, 8'h42);
      chk("pt_tgt_gp", o_tgt_gp, 3);
      chk("pt_gp_we", o_tgt_gp_we, 1);
      chk("pt_result", o_result, 24'h000777);
      chk("pt_sr_result", o_sr_result, 48'h000000ABCDEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
